// File: rtl/kogge_pipe.sv
// rtl/kogge_pipe.sv - pipelined Kogge-Stone adder/subtractor with valid/ready streaming
// One register stage per prefix level; all stages hold together while the output is stalled.
module kogge_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int LEVELS = $clog2(WIDTH);

  logic                          stall;
  logic [WIDTH-1:0]              b_eff;
  logic                          c_in;
  logic [LEVELS:0][WIDTH-1:0]    g_q, g_d;
  logic [LEVELS:0][WIDTH-1:0]    x_q, x_d;
  logic [LEVELS-1:0][WIDTH-1:0]  p_q, p_d;
  logic [LEVELS:0]               c0_q, c0_d;
  logic [LEVELS:0]               am_q, am_d;
  logic [LEVELS:0]               bm_q, bm_d;
  logic [LEVELS:0]               v_q, v_d;
  logic [WIDTH-1:0]              carries;
  logic [WIDTH-1:0]              s_q, s_d;
  logic                          cout_q, cout_d;
  logic                          ovf_q, ovf_d;
  logic                          vo_q;

  assign stall     = vo_q & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = vo_q;
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  always_comb begin
    b_eff = sub ? ~b : b;
    c_in  = sub | cin;
    g_d   = '0;
    p_d   = '0;
    x_d   = '0;

    g_d[0]    = a & b_eff;
    // carry-in rides in as part of bit 0's generate, so prefix outputs are final carries
    g_d[0][0] = (a[0] & b_eff[0]) | ((a[0] ^ b_eff[0]) & c_in);
    p_d[0]    = a ^ b_eff;
    x_d[0]    = a ^ b_eff;
    c0_d[0]   = c_in;
    am_d[0]   = a[WIDTH-1];
    bm_d[0]   = b_eff[WIDTH-1];
    v_d[0]    = in_valid & ~stall;

    for (int k = 1; k <= LEVELS; k++) begin
      g_d[k]  = g_q[k-1] | (p_q[k-1] & (g_q[k-1] << (1 << (k - 1))));
      x_d[k]  = x_q[k-1];
      c0_d[k] = c0_q[k-1];
      am_d[k] = am_q[k-1];
      bm_d[k] = bm_q[k-1];
      v_d[k]  = v_q[k-1];
    end
    // low positions shift in ones so their group propagate passes through unchanged
    for (int k = 1; k < LEVELS; k++) begin
      p_d[k] = p_q[k-1] & ((p_q[k-1] << (1 << (k - 1))) | ~({WIDTH{1'b1}} << (1 << (k - 1))));
    end

    carries = {g_q[LEVELS][WIDTH-2:0], c0_q[LEVELS]};
    s_d     = x_q[LEVELS] ^ carries;
    cout_d  = g_q[LEVELS][WIDTH-1];
    ovf_d   = (am_q[LEVELS] == bm_q[LEVELS]) && (s_d[WIDTH-1] != am_q[LEVELS]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      g_q    <= '0;
      p_q    <= '0;
      x_q    <= '0;
      c0_q   <= '0;
      am_q   <= '0;
      bm_q   <= '0;
      v_q    <= '0;
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      vo_q   <= 1'b0;
    end else if (!stall) begin
      g_q    <= g_d;
      p_q    <= p_d;
      x_q    <= x_d;
      c0_q   <= c0_d;
      am_q   <= am_d;
      bm_q   <= bm_d;
      v_q    <= v_d;
      s_q    <= s_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      vo_q   <= v_q[LEVELS];
    end
  end
endmodule

// File: tb/tb_kogge_pipe.sv
// tb/tb_kogge_pipe.sv - self-checking bench for kogge_pipe at WIDTH=8 and WIDTH=32
// Directed table vectors, latency/backpressure/reset sequences, and a random 32-bit stream.
module tb_kogge_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic iv8, ir8, ov8, or8, cin8, sub8, co8, ovf8;
  logic [7:0] a8, b8, s8;
  logic iv32, ir32, ov32, or32, cin32, sub32, co32, ovf32;
  logic [31:0] a32, b32, s32;

  kogge_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .s(s8),
    .cout(co8), .ovf(ovf8));

  kogge_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .cin(cin32), .sub(sub32), .out_valid(ov32), .out_ready(or32), .s(s32),
    .cout(co32), .ovf(ovf32));

  typedef struct packed { logic [7:0] s; logic co; logic ovf; } r8_t;
  typedef struct { logic [7:0] a; logic [7:0] b; logic cin; logic sub; r8_t r; } vec8_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic vec8_t mk(input int a, input int b, input bit cin, input bit sub,
                               input int s, input bit co, input bit ov);
    vec8_t v;
    v.a = a[7:0]; v.b = b[7:0]; v.cin = cin; v.sub = sub;
    v.r = '{s: s[7:0], co: co, ovf: ov};
    return v;
  endfunction

  function automatic logic [33:0] model32(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
    logic [31:0] be;
    logic [32:0] sum;
    be  = sub ? ~b : b;
    sum = {1'b0, a} + {1'b0, be} + {32'd0, (sub ? 1'b1 : cin)};
    return {((a[31] == be[31]) && (sum[31] != a[31])), sum};
  endfunction

  // 8-bit scoreboard: expected results travel with each accepted beat
  r8_t q8[$];
  r8_t cur8, e8;
  int pops8 = 0;
  int stall_cnt8 = 0;
  int out_cyc[64];
  logic stall_seen8 = 1'b0;
  logic [7:0] stall_s8;

  always @(negedge clk) begin
    #1;
    if (rst) begin
      q8.delete();
      stall_seen8 = 1'b0;
    end else begin
      if (iv8 && ir8) q8.push_back(cur8);
      if (ov8 && !or8) begin
        stall_cnt8++;
        chk("stall8_in_ready", ir8, 0);
        if (stall_seen8) chk("stall8_s_hold", s8, stall_s8);
        stall_seen8 = 1'b1;
        stall_s8 = s8;
      end else begin
        stall_seen8 = 1'b0;
      end
      if (ov8 && or8) begin
        if (q8.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out8_unexpected actual s=%0d required=no output", s8);
        end else begin
          e8 = q8.pop_front();
          chk("out8_s", s8, e8.s);
          chk("out8_cout", co8, e8.co);
          chk("out8_ovf", ovf8, e8.ovf);
          if (pops8 < 64) out_cyc[pops8] = cyc;
          pops8++;
        end
      end
    end
  end

  // 32-bit scoreboard driven by a behavioural reference
  logic [33:0] q32[$];
  logic [33:0] e32;
  int pushes32 = 0;
  int pops32 = 0;
  logic stall_seen32 = 1'b0;
  logic [31:0] stall_s32;

  always @(negedge clk) begin
    #1;
    if (rst) begin
      q32.delete();
      stall_seen32 = 1'b0;
    end else begin
      chk("in_ready32", ir32, !(ov32 && !or32));
      if (iv32 && ir32) begin
        q32.push_back(model32(a32, b32, cin32, sub32));
        pushes32++;
      end
      if (ov32 && !or32) begin
        if (stall_seen32) chk("stall32_s_hold", s32, stall_s32);
        stall_seen32 = 1'b1;
        stall_s32 = s32;
      end else begin
        stall_seen32 = 1'b0;
      end
      if (ov32 && or32) begin
        if (q32.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out32_unexpected actual s=0x%0h required=no output", s32);
        end else begin
          e32 = q32.pop_front();
          chk("out32_s", s32, e32[31:0]);
          chk("out32_cout", co32, e32[32]);
          chk("out32_ovf", ovf32, e32[33]);
          pops32++;
        end
      end
    end
  end

  // called on a falling edge; returns on the falling edge after acceptance
  task automatic send8(input vec8_t v);
    int n;
    n = 0;
    a8 = v.a; b8 = v.b; cin8 = v.cin; sub8 = v.sub; cur8 = v.r; iv8 = 1'b1;
    #2;
    while (!ir8 && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (!ir8) begin
      checks++;
      errors++;
      $display("FAIL send8_timeout actual in_ready=0 required=1");
    end
    @(negedge clk);
    iv8 = 1'b0;
  endtask

  task automatic lat8(input vec8_t v);
    a8 = v.a; b8 = v.b; cin8 = v.cin; sub8 = v.sub; cur8 = v.r; iv8 = 1'b1;
    #2;
    chk("lat8_accept", ir8, 1);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      iv8 = 1'b0;
      #2;
      chk("lat8_out_valid", ov8, (n == 5));
    end
  endtask

  task automatic drain8(input int base, input int want);
    for (int n = 0; n < 60 && (pops8 - base) < want; n++) @(negedge clk);
  endtask

  vec8_t tbl[10];
  vec8_t bp[6];
  int base;
  int acc;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = mk(5, 8, 1, 0, 14, 0, 0);
    tbl[1] = mk(15, 15, 1, 0, 31, 0, 0);
    tbl[2] = mk(255, 255, 1, 0, 255, 1, 0);
    tbl[3] = mk(0, 0, 0, 0, 0, 0, 0);
    tbl[4] = mk(5, 8, 1, 1, 253, 0, 0);
    tbl[5] = mk(8, 5, 0, 1, 3, 1, 0);
    tbl[6] = mk(127, 1, 0, 0, 128, 0, 1);
    tbl[7] = mk(128, 1, 0, 1, 127, 1, 1);
    tbl[8] = mk(8, 5, 1, 1, 3, 1, 0);
    tbl[9] = mk(255, 1, 0, 0, 0, 1, 0);
    bp[0] = mk(1, 2, 0, 0, 3, 0, 0);
    bp[1] = mk(10, 20, 1, 0, 31, 0, 0);
    bp[2] = mk(200, 100, 0, 0, 44, 1, 0);
    bp[3] = mk(100, 100, 0, 0, 200, 0, 1);
    bp[4] = mk(3, 250, 0, 1, 9, 0, 0);
    bp[5] = mk(250, 3, 0, 1, 247, 1, 0);

    rst = 1'b1;
    iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; cur8 = '0;
    iv32 = 1'b0; or32 = 1'b1; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_in_ready_during", ir8, 1);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("rst_out_valid8", ov8, 0);
    chk("rst_s8", s8, 0);
    chk("rst_cout8", co8, 0);
    chk("rst_ovf8", ovf8, 0);
    chk("rst_in_ready8", ir8, 1);
    chk("rst_out_valid32", ov32, 0);

    // single-beat latency
    @(negedge clk);
    lat8(mk(7, 29, 1, 0, 37, 0, 0));

    // back-to-back table vectors
    @(negedge clk);
    base = pops8;
    for (int i = 0; i < 10; i++) send8(tbl[i]);
    drain8(base, 10);
    chk("b2b_count", pops8 - base, 10);
    chk("b2b_consecutive", out_cyc[base + 9] - out_cyc[base], 9);

    // backpressure window
    @(negedge clk);
    base = pops8;
    fork
      begin
        for (int i = 0; i < 6; i++) send8(bp[i]);
      end
      begin
        for (int k = 0; k < 16; k++) begin
          or8 = !(k >= 3 && k <= 10);
          @(negedge clk);
        end
        or8 = 1'b1;
      end
    join
    drain8(base, 6);
    chk("bp_count", pops8 - base, 6);
    chk("bp_stalled", (stall_cnt8 != 0), 1);

    // reset with three beats in flight
    @(negedge clk);
    send8(mk(1, 1, 0, 0, 2, 0, 0));
    send8(mk(2, 2, 0, 0, 4, 0, 0));
    send8(mk(3, 3, 0, 0, 6, 0, 0));
    rst = 1'b1;
    #2;
    chk("midrst_in_ready", ir8, 1);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("midrst_out_valid", ov8, 0);
    chk("midrst_s", s8, 0);
    chk("midrst_cout", co8, 0);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      #2;
      chk("midrst_no_stale", ov8, 0);
    end
    @(negedge clk);
    lat8(mk(128, 128, 0, 0, 0, 1, 1));

    // 32-bit carry through every bit, latency 7
    @(negedge clk);
    a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; cin32 = 1'b0; sub32 = 1'b0; iv32 = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      iv32 = 1'b0;
      #2;
      chk("lat32_out_valid", ov32, (n == 7));
      if (n == 7) begin
        chk("w32_s", s32, 32'h0);
        chk("w32_cout", co32, 1);
        chk("w32_ovf", ovf32, 0);
      end
    end

    // random stream with random backpressure
    acc = 0;
    for (int c = 0; c < 20000 && acc < 1000; c++) begin
      @(negedge clk);
      iv32  = ($urandom_range(0, 3) != 0);
      or32  = ($urandom_range(0, 3) != 0);
      a32   = $urandom();
      b32   = ($urandom_range(0, 7) == 0) ? ~a32 : $urandom();
      cin32 = ($urandom_range(0, 1) != 0);
      sub32 = ($urandom_range(0, 1) != 0);
      #2;
      if (iv32 && ir32) acc++;
    end
    @(negedge clk);
    iv32 = 1'b0;
    or32 = 1'b1;
    for (int n = 0; n < 40 && pops32 < pushes32; n++) @(negedge clk);
    chk("rand_accepted", acc, 1000);
    chk("rand_all_out", pops32, pushes32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/kogge_pipe.md
Name: kogge_pipe

Overview:
- Pipelined, parametrised successor to the combinational Kogge-Stone adder `kogge`.
- Registers every prefix level so wide adders close timing at high clock rates.
- Adds add/subtract mode, a signed-overflow flag and valid/ready streaming handshakes on both sides.
- Sits in datapaths that feed a sustained operand stream: one operation per cycle, full backpressure support.

Parameters:
- WIDTH, 8, operand/sum width in bits; any integer >= 2.
- LEVELS, derived = clog2(WIDTH), number of prefix levels; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  operand beat accepted when in_valid && in_ready.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0: a+b+cin; 1: a-b (cin ignored).
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts result.
- s  output  WIDTH  sum/difference.
- cout  output  1  carry-out; in sub mode 1 = no borrow (a >= b unsigned).
- ovf  output  1  signed overflow of the WIDTH-bit two's-complement result.

Behaviour:
- Operand prep: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage 0 registers p = a^b_eff, g = a&b_eff, c0, and the operand MSBs.
- Stages 1..LEVELS each register one Kogge-Stone prefix level: span 2^(k-1), (G,P) = (Gh | Ph&Gl, Ph&Pl).
- c0 is folded in as bit -1 generate, so carries need no final ripple.
- Final stage registers s = p ^ carries, cout, ovf = (a_msb == b_eff_msb) && (s_msb != a_msb).
- Latency: LEVELS+2 cycles from acceptance to out_valid (WIDTH=8 -> 5 cycles). Throughput is 1 beat/cycle.
- Each stage carries a valid bit. Bubbles propagate as invalid stages and are not collapsed.
- Stall = out_valid && !out_ready.
  - While stalled, every stage register, including all valid bits, holds.
  - s/cout/ovf are stable while out_valid=1 and out_ready=0.
- in_ready = !stall. It is combinational from out_ready and has no dependence on in_valid.
- Beat not accepted (in_valid=0 or in_ready=0): a 0 valid enters stage 0 if not stalled; stage 0 data is don't-care.
- Simultaneous acceptance and output while out_ready=1: both happen in the same cycle with no bubble.
- Reset (rst=1 at a clock edge):
  - All valid bits clear; s, cout, ovf and all data registers go to 0.
  - out_valid=0 on the following cycle.
  - In-flight beats are discarded, including a reset mid-stall.
  - in_ready=1 during and after reset (out_valid=0).
- Arithmetic wraps modulo 2^WIDTH. cout is the (WIDTH+1)th bit of the sum (add) or of a + ~b + 1 (sub).
- No state machine beyond per-stage valid bits. Ordering is strictly FIFO: results leave in acceptance order.

Test Plan:
- WIDTH=8, out_ready=1, single beat a=7, b=29, cin=1, sub=0 -> out_valid exactly 5 cycles later; s=37, cout=0, ovf=0.
- Back-to-back beats, one per cycle:
  - (5,8,1) -> s=14, cout=0.
  - (15,15,1) -> s=31, cout=0.
  - (255,255,1) -> s=255, cout=1.
  - (0,0,0) -> s=0, cout=0.
  - Results arrive on consecutive cycles in order.
- Subtract and overflow:
  - a=5, b=8, sub=1, cin=1 -> s=253, cout=0, ovf=0.
  - a=8, b=5, sub=1 -> s=3, cout=1.
  - a=127, b=1, sub=0, cin=0 -> s=128, ovf=1.
  - a=128, b=1, sub=1 -> s=127, ovf=1.
- Backpressure:
  - Stream 6 beats with out_ready=0 from cycle 3 to cycle 10.
  - Required: in_ready=0 whenever out_valid=1 during the stall, and s holds stable.
  - After release, all 6 results appear in order with none lost or duplicated.
- Reset mid-stream: assert rst for 1 cycle with 3 beats in flight -> out_valid=0, s=0 next cycle; no pre-reset result ever emerges; a new beat after reset completes in 5 cycles.
- Parametric, WIDTH=32 (latency 7): a=0xFFFFFFFF, b=0x00000001, cin=0 -> s=0, cout=1, ovf=0, followed by 1000 random beats with random out_ready checked against a reference model.
